// File: rtl/sumador_pkg.sv
// Shared types and helpers for the serial adder/subtractor.
package sumador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk index width; at least one bit even when there is a single chunk.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sumador_serial_adder_chunk.sv
// Combinational CHUNK-bit adder with carry-in/carry-out; the one shared carry chain.
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_entAcarreo,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_salAcarreo
);

    assign {o_salAcarreo, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_entAcarreo};

endmodule

// File: rtl/sumador_serial.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands summed CHUNK bits per clock
// through one shared chunk adder, with an inicio/listo/valido handshake.
module sumador_serial
    import sumador_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inicio,
    input  logic             i_resta,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_entAcarreo,
    output logic             o_listo,
    output logic             o_ocupado,
    output logic             o_valido,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_salAcarreo,
    output logic             o_desbordamiento
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IW-1:0]    r_k;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [CHUNK-1:0] w_chunk_a;
    logic [CHUNK-1:0] w_chunk_b;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    assign w_chunk_a = r_a[r_k*CHUNK +: CHUNK];
    assign w_chunk_b = r_b[r_k*CHUNK +: CHUNK];
    assign w_last    = (r_k == IW'(NCHUNK - 1));

    adder_chunk #(.CHUNK(CHUNK)) u_adder_chunk (
        .i_a          (w_chunk_a),
        .i_b          (w_chunk_b),
        .i_entAcarreo (r_carry),
        .o_sum        (w_chunk_sum),
        .o_salAcarreo (w_chunk_cout)
    );

    // Full result including the chunk being added now, so DONE sees all slices.
    always_comb begin
        w_res_next = r_res;
        w_res_next[r_k*CHUNK +: CHUNK] = w_chunk_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_inicio) w_state_next = CALC;
            CALC:    if (w_last)   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_inicio) begin
                        r_a     <= i_a;
                        r_b     <= i_resta ? ~i_b : i_b;
                        r_carry <= i_entAcarreo;
                        r_k     <= '0;
                    end
                end
                CALC: begin
                    r_res   <= w_res_next;
                    r_carry <= w_chunk_cout;
                    r_k     <= r_k + IW'(1);
                    if (w_last) begin
                        r_sum  <= w_res_next;
                        r_cout <= w_chunk_cout;
                        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                  (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_listo          = (r_state == IDLE);
    assign o_ocupado        = (r_state != IDLE);
    assign o_valido         = (r_state == DONE);
    assign o_sum            = r_sum;
    assign o_salAcarreo     = r_cout;
    assign o_desbordamiento = r_ovf;

endmodule

// File: tb/tb_sumador_serial.sv
// Scoreboard bench for sumador_serial: 32/8 instance under random and directed
// traffic, plus an 8/8 instance for the single-chunk timing.
module tb_sumador_serial;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inicio = 1'b0, resta = 1'b0, cin = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        listo, ocupado, valido, cout, ovf;
    logic [31:0] sum;

    logic        inicio8 = 1'b0, resta8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        listo8, ocupado8, valido8, cout8, ovf8;
    logic [7:0]  sum8;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t hold = '{sum: 32'h0, cout: 1'b0, ovf: 1'b0};

    always #5 clk = ~clk;

    sumador_serial #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_inicio(inicio), .i_resta(resta),
        .i_a(a), .i_b(b), .i_entAcarreo(cin),
        .o_listo(listo), .o_ocupado(ocupado), .o_valido(valido),
        .o_sum(sum), .o_salAcarreo(cout), .o_desbordamiento(ovf)
    );

    sumador_serial #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .i_inicio(inicio8), .i_resta(resta8),
        .i_a(a8), .i_b(b8), .i_entAcarreo(cin8),
        .o_listo(listo8), .o_ocupado(ocupado8), .o_valido(valido8),
        .o_sum(sum8), .o_salAcarreo(cout8), .o_desbordamiento(ovf8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide unsigned sum for result/carry, signed range test for overflow.
    function automatic exp_t model32(input logic [31:0] x, input logic [31:0] y,
                                     input logic rs, input logic ci);
        exp_t        e;
        logic [31:0] yp;
        logic [63:0] u;
        longint      s;
        yp     = rs ? ~y : y;
        u      = {32'b0, x} + {32'b0, yp} + {63'b0, ci};
        s      = longint'($signed(x)) + longint'($signed(yp)) + longint'(ci);
        e.sum  = u[31:0];
        e.cout = u[32];
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return e;
    endfunction

    // Scoreboard monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            hold = '{sum: 32'h0, cout: 1'b0, ovf: 1'b0};
        end else if (valido) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valido: got valido=1 sum=0x%0h expected no result pending", sum);
            end else begin
                hold = sb_q.pop_front();
                check("sum", 64'(sum), 64'(hold.sum));
                check("salAcarreo", 64'(cout), 64'(hold.cout));
                check("desbordamiento", 64'(ovf), 64'(hold.ovf));
            end
        end else begin
            check("hold_sum", 64'(sum), 64'(hold.sum));
            check("hold_flags", 64'({cout, ovf}), 64'({hold.cout, hold.ovf}));
        end
    end

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic rs, input logic ci);
        int n;
        n = 0;
        @(negedge clk);
        while (!listo && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!listo) begin
            check("listo_timeout", 64'(listo), 64'(1));
        end else begin
            a = x; b = y; resta = rs; cin = ci; inicio = 1'b1;
            sb_q.push_back(model32(x, y, rs, ci));
            @(posedge clk);
            #1 inicio = 1'b0;
        end
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic rs, input logic ci);
        logic [7:0] yp;
        int         u, s;
        int         n;
        yp = rs ? ~y : y;
        u  = int'(x) + int'(yp) + int'(ci);
        s  = int'($signed(x)) + int'($signed(yp)) + int'(ci);
        n  = 0;
        @(negedge clk);
        while (!listo8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("listo8_before", 64'(listo8), 64'(1));
        a8 = x; b8 = y; resta8 = rs; cin8 = ci; inicio8 = 1'b1;
        @(posedge clk);
        #1 inicio8 = 1'b0;
        @(negedge clk);
        check("e0_8_state", 64'({listo8, ocupado8, valido8}), 64'(3'b010));
        @(negedge clk);
        check("e1_8_valido", 64'({listo8, valido8}), 64'(2'b01));
        check("e1_8_sum", 64'(sum8), 64'(u[7:0]));
        check("e1_8_cout", 64'(cout8), 64'(u[8]));
        check("e1_8_ovf", 64'(ovf8), 64'((s > 127) || (s < -128)));
        @(negedge clk);
        check("e2_8_listo", 64'({listo8, valido8}), 64'(2'b10));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 64'({listo, ocupado, valido, cout, ovf}), 64'(5'b10000));
        check("reset_sum", 64'(sum), 64'(0));
        #1 rst_n = 1'b1;

        // Basic add with cycle-by-cycle handshake timing.
        do_op(32'd5, 32'd5, 1'b0, 1'b1);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("listo_after_E%0d", c), 64'(listo), 64'(c == 5));
            check($sformatf("valido_after_E%0d", c), 64'(valido), 64'(c == 4));
        end

        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        do_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        do_op(32'd11, 32'd4, 1'b1, 1'b1);
        do_op(32'd4, 32'd11, 1'b1, 1'b1);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

        // inicio and operand churn while busy must not start anything.
        do_op(32'd8, 32'd6, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            inicio = (i < 4);
            a = (i == 0) ? 32'd2 : ~a;
            b = (i == 0) ? 32'd9 : ~b;
            resta = ~resta;
            cin = ~cin;
        end
        inicio = 1'b0;

        // Reset mid-CALC aborts without valido.
        do_op(32'd20, 32'd30, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_flags", 64'({listo, ocupado, valido, cout, ovf}), 64'(5'b10000));
        check("abort_sum", 64'(sum), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_op(32'd4, 32'd7, 1'b0, 1'b0);

        // Random traffic; inicio may stay high to exercise back-to-back acceptance.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            inicio = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       a = 32'hFFFF_FFFF;
                1:       a = 32'h7FFF_FFFF ^ $urandom_range(0, 3);
                default: a = $urandom;
            endcase
            b     = ($urandom_range(0, 4) == 0) ? 32'(($urandom_range(0, 2))) : $urandom;
            resta = $urandom_range(0, 1) == 1;
            cin   = $urandom_range(0, 1) == 1;
            if (listo && inicio) sb_q.push_back(model32(a, b, resta, cin));
        end
        @(negedge clk);
        inicio = 1'b0;

        n = 0;
        while ((sb_q.size() != 0 || !listo) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

        // Single-chunk instance.
        op8(8'd5, 8'd5, 1'b0, 1'b1);
        op8(8'h7F, 8'd1, 1'b0, 1'b0);
        op8(8'd4, 8'd11, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            op8(8'($urandom), 8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sumador_serial.md
# sumador_serial

Multi-cycle, parametrised two's-complement adder/subtractor that processes WIDTH-bit operands CHUNK bits per clock through one shared CHUNK-bit carry adder, with an explicit start/ready/done handshake. It supersedes the fixed 8-bit combinational adder in datapaths where operand width exceeds what a single-cycle carry chain can close timing on. Carry-in and carry-out semantics match the 8-bit adder, extended with a subtract mode and signed-overflow reporting.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK
- CHUNK, 8, bits added per cycle; NCHUNK = WIDTH/CHUNK, NCHUNK ≥ 1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- inicio  in  1  start request; accepted only on a rising edge where listo=1
- resta  in  1  0: a+b+entAcarreo; 1: a+~b+entAcarreo (entAcarreo=1 gives a−b)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- entAcarreo  in  1  carry-in to chunk 0
- listo  out  1  block idle, inicio will be accepted
- ocupado  out  1  operation in progress (CALC or DONE)
- valido  out  1  one-cycle pulse: result outputs are valid
- sum  out  WIDTH  result
- salAcarreo  out  1  carry-out of the MSB (for subtract: 1 = no borrow)
- desbordamiento  out  1  signed overflow of the operation

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: listo=1, ocupado=0. On edge with inicio=1: latch a, b (inverted if resta=1), entAcarreo into carry register, clear chunk index to 0, go to CALC.
- CALC: each edge adds chunk k of the latched operands plus the carry register. It writes the CHUNK-bit result into the internal result register at slice k, stores the chunk carry-out and increments k. After chunk NCHUNK−1, go to DONE.
- DONE: sum, salAcarreo and desbordamiento are loaded into the output registers on the CALC→DONE edge. valido=1 for exactly this cycle. The next edge returns to IDLE.
- desbordamiento = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is b after optional inversion.
- Result outputs hold their values from DONE until the next DONE. They do not change during CALC.
- inicio is ignored in CALC and DONE; there is no queuing. Changes on a, b, resta and entAcarreo after acceptance have no effect.
- Reset (any state, including mid-CALC): aborts the operation with no valido. State becomes IDLE. sum=0, salAcarreo=0, desbordamiento=0, valido=0, ocupado=0, listo=1.

## Timing
- Acceptance edge E0. Chunk k is registered at edge E(k+1). valido is high in the cycle following E(NCHUNK). listo returns high after E(NCHUNK+1).
- Latency from acceptance to valido: NCHUNK+1 edges. Throughput: one operation per NCHUNK+2 cycles (inicio held high continuously is accepted every NCHUNK+2 cycles).
- NCHUNK=1: CALC lasts one cycle. valido is high after E1. listo is high again after E2.
- listo and ocupado are decoded from state register only, with no combinational path from inputs.
- Critical path is one CHUNK-bit carry chain plus the operand slice mux.

## Structure
- Package sumador_pkg: state enum (IDLE, CALC, DONE) and a function computing the index width, clog2(NCHUNK) with a minimum of 1.
- Sub-module adder_chunk #(CHUNK): combinational a+b+entAcarreo → sum, salAcarreo, with the same port semantics as the 8-bit adder. Instantiated once.
- Top holds the FSM, chunk counter, latched operands, carry register, internal result register and output registers.

## Test plan
All items use WIDTH=32, CHUNK=8 unless stated.

- a=5, b=5, entAcarreo=1, resta=0 → sum=11, salAcarreo=0, desbordamiento=0. valido is high after E4 exactly once. listo is low from E0 until after E5.
- a=0xFFFFFFFF, b=1, entAcarreo=0 → sum=0, salAcarreo=1, desbordamiento=0. This is a carry ripple across all four chunks.
- a=0x7FFFFFFF, b=1, entAcarreo=0 → sum=0x80000000, salAcarreo=0, desbordamiento=1.
- resta=1, entAcarreo=1: a=11, b=4 → sum=7, salAcarreo=1. Then a=4, b=11 → sum=0xFFFFFFF9, salAcarreo=0, desbordamiento=0.
- Start a=8, b=6. During CALC, pulse inicio with a=2, b=9 and toggle a/b every cycle → single valido with sum=14. Outputs remain stable from DONE until the next DONE.
- Assert rst_n low during CALC (after E2) → all outputs zero, no valido, listo=1. Next operation a=4, b=7 completes with sum=11.
- Repeat with WIDTH=8, CHUNK=8 → valido after E1, listo high after E2.
